// File: rtl/csr_perf_counters.sv
// rtl/csr_perf_counters.sv - machine-mode cycle/instret/HPM counter file with CSR access port
module csr_perf_counters #(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  retire_valid,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  csr_req,
    input  logic [1:0]            csr_op,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    output logic                  csr_ack,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal,
    output logic                  ovf_irq
);

    // Counter slots: 0 = cycle, 1 = instret, 2+i = hpm i.
    // CSR bit positions (inhibit/ovf): 0 = cycle, 2 = instret, 3+i = hpm i; bit 1 unused.
    localparam int NC = NUM_HPM + 2;
    localparam int NB = NUM_HPM + 3;
    localparam int EW = $clog2(NUM_EVENTS + 1);
    localparam int HW = CNT_WIDTH - 32;
    localparam int XW = 1 << EW;
    localparam logic [NB-1:0] IMPL_MASK = ~(NB'(2));

    logic [CNT_WIDTH-1:0] cnt [NC];
    logic [EW-1:0]        evsel [NUM_HPM];
    logic [NB-1:0]        inhibit;
    logic [NB-1:0]        ovf_status;
    logic [NB-1:0]        ovf_en;

    logic [NC-1:0]        sel_cnt;
    logic [NUM_HPM-1:0]   sel_ev;
    logic                 sel_hi;
    logic                 sel_ro;
    logic                 sel_inh;
    logic                 sel_ovs;
    logic                 sel_ove;
    logic                 illegal;
    logic                 do_wr;
    logic [31:0]          old_val;
    logic [31:0]          res_val;

    logic [XW-1:0]        ev_ext;
    logic [NC-1:0]        inc;
    logic [NC-1:0]        wrap;
    logic [NB-1:0]        ovf_set;
    logic [NB-1:0]        ovs_next;

    // Selector value k picks event_in[k-1]; value 0 lands on the constant-0 slot.
    assign ev_ext = XW'({event_in, 1'b0});

    // Address decode, old-value mux and read-modify result for the current request
    always_comb begin
        sel_cnt = '0;
        sel_ev  = '0;
        sel_hi  = csr_addr[7];
        sel_ro  = (csr_addr[11:8] == 4'hC);
        for (int k = 0; k < NC; k++) begin
            if ((csr_addr[11:8] == 4'hB || sel_ro) &&
                csr_addr[6:0] == 7'((k == 0) ? 0 : k + 1)) begin
                sel_cnt[k] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            sel_ev[i] = (csr_addr == 12'(12'h323 + i));
        end
        sel_inh = (csr_addr == 12'h320);
        sel_ovs = (csr_addr == 12'h7C0);
        sel_ove = (csr_addr == 12'h7C1);

        illegal = !((|sel_cnt) || (|sel_ev) || sel_inh || sel_ovs || sel_ove) ||
                  (sel_ro && (csr_op != 2'b00));

        old_val = '0;
        for (int k = 0; k < NC; k++) begin
            if (sel_cnt[k]) begin
                old_val = sel_hi ? 32'(cnt[k][CNT_WIDTH-1:32]) : cnt[k][31:0];
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (sel_ev[i]) begin
                old_val = 32'(evsel[i]);
            end
        end
        if (sel_inh) old_val = 32'(inhibit);
        if (sel_ovs) old_val = 32'(ovf_status);
        if (sel_ove) old_val = 32'(ovf_en);

        case (csr_op)
            2'b01:   res_val = csr_wdata;
            2'b10:   res_val = old_val | csr_wdata;
            2'b11:   res_val = old_val & ~csr_wdata;
            default: res_val = old_val;
        endcase

        do_wr = csr_req && !illegal && (csr_op != 2'b00);
    end

    // Increment enables from the pre-edge inhibit/selector settings, wrap detect and ovf_status next value
    always_comb begin
        inc[0] = !inhibit[0];
        inc[1] = retire_valid && !inhibit[2];
        for (int i = 0; i < NUM_HPM; i++) begin
            inc[2+i] = ev_ext[evsel[i]] && !inhibit[3+i];
        end
        for (int k = 0; k < NC; k++) begin
            // A counter written this edge takes the written value; its increment cannot wrap.
            wrap[k] = inc[k] && (&cnt[k]) && !(do_wr && sel_cnt[k]);
        end
        ovf_set  = {wrap[NC-1:1], 1'b0, wrap[0]};
        ovs_next = ovf_status;
        if (do_wr && sel_ovs && csr_op != 2'b11) begin
            ovs_next = ovs_next & ~csr_wdata[NB-1:0];
        end
        // New overflow is OR-ed after the W1C so a same-edge set wins.
        ovs_next = (ovs_next | ovf_set) & IMPL_MASK;
    end

    // State update: CSR writes override increments; registered CSR response and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                cnt[k] <= '0;
            end
            for (int i = 0; i < NUM_HPM; i++) begin
                evsel[i] <= '0;
            end
            inhibit     <= '0;
            ovf_status  <= '0;
            ovf_en      <= '0;
            csr_ack     <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
            ovf_irq     <= 1'b0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (do_wr && sel_cnt[k]) begin
                    if (sel_hi) begin
                        cnt[k][CNT_WIDTH-1:32] <= res_val[HW-1:0];
                    end else begin
                        cnt[k][31:0] <= res_val;
                    end
                end else if (inc[k]) begin
                    cnt[k] <= cnt[k] + CNT_WIDTH'(1);
                end
            end
            for (int i = 0; i < NUM_HPM; i++) begin
                if (do_wr && sel_ev[i]) begin
                    evsel[i] <= (res_val > 32'(NUM_EVENTS)) ? '0 : res_val[EW-1:0];
                end
            end
            if (do_wr && sel_inh) inhibit <= res_val[NB-1:0] & IMPL_MASK;
            if (do_wr && sel_ove) ovf_en  <= res_val[NB-1:0] & IMPL_MASK;
            ovf_status  <= ovs_next;
            csr_ack     <= csr_req;
            csr_illegal <= csr_req && illegal;
            csr_rdata   <= (csr_req && !illegal) ? old_val : '0;
            ovf_irq     <= |(ovf_status & ovf_en);
        end
    end

endmodule

// File: tb/tb_csr_perf_counters.sv
// tb/tb_csr_perf_counters.sv - randomized bench for csr_perf_counters against a behavioural model
module tb_csr_perf_counters;

    localparam int NH = 4;
    localparam int NE = 8;
    localparam int CW = 64;
    localparam int NB = NH + 3;
    localparam longint unsigned CMASK = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam longint unsigned BMASK = ((64'd1 << NB) - 64'd1) & ~64'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          retire_valid;
    logic [NE-1:0] event_in;
    logic          csr_req;
    logic [1:0]    csr_op;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic          csr_ack;
    logic [31:0]   csr_rdata;
    logic          csr_illegal;
    logic          ovf_irq;

    csr_perf_counters #(.NUM_HPM(NH), .NUM_EVENTS(NE), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .retire_valid (retire_valid),
        .event_in     (event_in),
        .csr_req      (csr_req),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_ack      (csr_ack),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .ovf_irq      (ovf_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_rdata;
    logic        last_ill;

    // Reference state: counters indexed by their CSR bit position (0 cycle, 2 instret, 3+i hpm)
    longint unsigned mc [NB];
    longint unsigned m_inh, m_ovs, m_ove;
    int              m_ev [NH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int j = 0; j < NB; j++) mc[j] = 0;
        for (int i = 0; i < NH; i++) m_ev[i] = 0;
        m_inh = 0;
        m_ovs = 0;
        m_ove = 0;
    endfunction

    task automatic cyc(input bit r, input bit req, input bit [1:0] op, input bit [11:0] addr,
                       input bit [31:0] wd, input bit ret, input bit [NE-1:0] ev);
        int a, b, sel;
        bit is_ctr, ro, hi, e_ill, e_irq, legal_wr, incr;
        longint unsigned old, res, newovf;
        rst = r; csr_req = req; csr_op = op; csr_addr = addr; csr_wdata = wd;
        retire_valid = ret; event_in = ev;

        e_irq = ((m_ovs & m_ove) != 0);
        a  = int'(addr);
        b  = a & 'h7F;
        hi = addr[7];
        ro = (a >> 8) == 'hC;
        is_ctr = ((a >> 8) == 'hB || ro) && (b == 0 || (b >= 2 && b < NB));
        old = 0;
        e_ill = 0;
        if (is_ctr) old = hi ? (mc[b] >> 32) : (mc[b] & 64'hFFFF_FFFF);
        else if (a == 'h320) old = m_inh;
        else if (a >= 'h323 && a < 'h323 + NH) old = longint'(m_ev[a - 'h323]);
        else if (a == 'h7C0) old = m_ovs;
        else if (a == 'h7C1) old = m_ove;
        else e_ill = 1;
        if (is_ctr && ro && op != 0) e_ill = 1;
        case (op)
            2'd1: res = longint'(wd);
            2'd2: res = old | longint'(wd);
            2'd3: res = old & ~longint'(wd);
            default: res = old;
        endcase
        res &= 64'hFFFF_FFFF;
        legal_wr = req && !e_ill && op != 0;

        // Counters advance under the settings in force before this edge.
        newovf = 0;
        for (int j = 0; j < NB; j++) begin
            if (j == 1) continue;
            if (j == 0) incr = !m_inh[0];
            else if (j == 2) incr = ret && !m_inh[2];
            else begin
                sel  = m_ev[j-3];
                incr = sel >= 1 && sel <= NE && ev[sel-1] && !m_inh[j];
            end
            if (legal_wr && is_ctr && b == j) begin
                if (hi) mc[j] = (mc[j] & 64'hFFFF_FFFF) | (res << 32);
                else    mc[j] = (mc[j] & ~64'hFFFF_FFFF) | res;
            end else if (incr) begin
                if (mc[j] == CMASK) begin
                    mc[j] = 0;
                    newovf |= 64'd1 << j;
                end else begin
                    mc[j] = mc[j] + 1;
                end
            end
        end
        if (legal_wr) begin
            if (a == 'h320) m_inh = res & BMASK;
            if (a == 'h7C1) m_ove = res & BMASK;
            if (a >= 'h323 && a < 'h323 + NH) m_ev[a - 'h323] = (res > NE) ? 0 : int'(res);
            if (a == 'h7C0 && op != 3) m_ovs &= ~longint'(wd);
        end
        m_ovs = (m_ovs | newovf) & BMASK;
        if (r) model_reset();

        @(posedge clk);
        #1;
        if (r) begin
            check("rst_ack", csr_ack, 0);
            check("rst_rdata", csr_rdata, 0);
            check("rst_illegal", csr_illegal, 0);
            check("rst_irq", ovf_irq, 0);
        end else begin
            check("ack", csr_ack, req);
            if (req) begin
                check($sformatf("illegal@%03h", addr), csr_illegal, e_ill);
                check($sformatf("rdata@%03h", addr), csr_rdata, e_ill ? 0 : old);
            end
            check("ovf_irq", ovf_irq, e_irq);
        end
        last_rdata = csr_rdata;
        last_ill   = csr_illegal;
    endtask

    task automatic rd(input bit [11:0] a);
        cyc(0, 1, 2'b00, a, 0, 0, '0);
    endtask

    task automatic wr(input bit [11:0] a, input bit [31:0] d);
        cyc(0, 1, 2'b01, a, d, 0, '0);
    endtask

    task automatic idle();
        cyc(0, 0, 2'b00, 12'h000, 0, 0, '0);
    endtask

    bit [11:0] alist [] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84,
                            12'hB06, 12'hB86, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC85,
                            12'h320, 12'h323, 12'h324, 12'h326, 12'h7C0, 12'h7C1, 12'h7FF, 12'hB01,
                            12'hC01, 12'hB07, 12'h321, 12'h327};

    initial begin
        bit [7:0]  rpat;
        bit [11:0] ra;
        bit [31:0] rw;
        bit [1:0]  rop;
        model_reset();
        cyc(1, 0, 2'b00, 12'h000, 0, 0, '0);
        cyc(1, 1, 2'b00, 12'hB00, 0, 1, '1);

        for (int i = 0; i < 10; i++) idle();
        rd(12'hB00);
        check("cycle_at_10", last_rdata, 10);
        rd(12'hB80);
        check("cycle_hi_zero", last_rdata, 0);

        wr(12'hB02, 0);
        wr(12'hB82, 0);
        rpat = 8'b1010_0111;
        for (int j = 0; j < 8; j++) begin
            if (j == 4) cyc(0, 1, 2'b01, 12'h320, 32'h4, rpat[j], '0);
            else        cyc(0, 0, 2'b00, 12'h000, 0, rpat[j], '0);
        end
        rd(12'hB02);
        check("instret_inhibited", last_rdata, 3);
        rd(12'hC02);
        check("instret_shadow", last_rdata, 3);
        wr(12'h320, 0);

        wr(12'h323, 2);
        wr(12'hB03, 0);
        wr(12'hB83, 0);
        for (int j = 0; j < 11; j++) cyc(0, 0, 2'b00, 12'h000, 0, 0, (j < 7) ? 8'h02 : 8'h01);
        rd(12'hB03);
        check("hpm3_events", last_rdata, 7);
        wr(12'h323, NE + 1);
        rd(12'h323);
        check("evsel_oob", last_rdata, 0);
        cyc(0, 0, 2'b00, 12'h000, 0, 0, 8'h02);
        cyc(0, 0, 2'b00, 12'h000, 0, 0, 8'hFF);
        rd(12'hB03);
        check("hpm3_stopped", last_rdata, 7);

        wr(12'h323, 1);
        wr(12'h7C1, 32'h8);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        cyc(0, 0, 2'b00, 12'h000, 0, 0, 8'h01);
        rd(12'hB03);
        check("hpm3_wrapped", last_rdata, 0);
        check("irq_after_ovf", ovf_irq, 1);
        rd(12'h7C0);
        check("ovf_status_bit3", last_rdata, 32'h8);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        cyc(0, 1, 2'b01, 12'h7C0, 32'h8, 0, 8'h01);
        rd(12'h7C0);
        check("w1c_vs_set", last_rdata, 32'h8);
        wr(12'h7C0, 32'h8);
        rd(12'h7C0);

        cyc(0, 1, 2'b01, 12'hC00, 32'h1234, 0, '0);
        check("c00_write_illegal", last_ill, 1);
        rd(12'hB00);
        rd(12'h7FF);
        check("unmapped_illegal", last_ill, 1);

        for (int n = 0; n < 1500; n++) begin
            ra  = alist[$urandom_range(0, alist.size() - 1)];
            rop = 2'($urandom_range(0, 3));
            if (ra >= 12'h323 && ra <= 12'h326) rw = $urandom_range(0, 12);
            else if (ra == 12'h320)             rw = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            else if ($urandom_range(0, 3) == 0) rw = 32'hFFFF_FFFF;
            else                                rw = $urandom;
            cyc(0, $urandom_range(0, 9) < 7, rop, ra, rw, 1'($urandom), NE'($urandom));
        end

        cyc(1, 1, 2'b01, 12'hB00, 32'h1234, 1, '1);
        rd(12'hB00);
        check("cycle_after_rst", last_rdata, 0);
        rd(12'h7C0);
        rd(12'hB03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
